// File: rtl/inventory_ctrl.sv
// Gen2 tag inventory control unit: tag state machine, slot sequencer driving the RNG slot
// counter, RN16 latch and ACK validation.
module inventory_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid_dec,
    input  logic [2:0]  i_cmd_type_dec,
    input  logic [3:0]  i_q_field_dec,
    input  logic [2:0]  i_updn_dec,
    input  logic [15:0] i_rn16_dec,
    input  logic [15:0] i_random_rng,
    input  logic        i_slotz_rng,
    output logic [3:0]  o_q_cu,
    output logic        o_newSlot_cu,
    output logic        o_decSlot_cu,
    output logic        o_reply_rn16_cu,
    output logic        o_reply_epc_cu,
    output logic [15:0] o_rn16_cu,
    output logic [1:0]  o_state_cu,
    output logic        o_busy_cu
);

    typedef enum logic [1:0] {
        TagReady     = 2'd0,
        TagArbitrate = 2'd1,
        TagReply     = 2'd2,
        TagAcked     = 2'd3
    } tag_state_e;

    typedef enum logic [1:0] {
        SeqIdle = 2'd0,
        SeqSlot = 2'd1,
        SeqEval = 2'd2
    } seq_state_e;

    localparam logic [2:0] CmdQuery    = 3'd0;
    localparam logic [2:0] CmdQueryRep = 3'd1;
    localparam logic [2:0] CmdQueryAdj = 3'd2;
    localparam logic [2:0] CmdAck      = 3'd3;
    localparam logic [2:0] CmdNak      = 3'd4;

    localparam logic [2:0] UpdnInc  = 3'b110;
    localparam logic [2:0] UpdnDec  = 3'b011;
    localparam logic [2:0] UpdnKeep = 3'b000;

    tag_state_e tag_q, tag_d;
    seq_state_e seq_q, seq_d;
    logic [3:0]  q_q, q_d;
    logic [15:0] rn16_q, rn16_d;
    logic        dec_q, dec_d;          // slot kind of the running sequence: 1 = decrement
    logic        reply_rn16_q, reply_rn16_d;
    logic        reply_epc_q, reply_epc_d;
    logic        updn_ok;

    assign updn_ok = (i_updn_dec == UpdnInc) || (i_updn_dec == UpdnDec) ||
                     (i_updn_dec == UpdnKeep);

    // Next-state: sequencer phases take priority; commands are only decoded while idle.
    always_comb begin
        tag_d        = tag_q;
        seq_d        = seq_q;
        q_d          = q_q;
        rn16_d       = rn16_q;
        dec_d        = dec_q;
        reply_rn16_d = 1'b0;
        reply_epc_d  = 1'b0;
        case (seq_q)
            SeqSlot: seq_d = SeqEval;
            SeqEval: begin
                seq_d = SeqIdle;
                if (i_slotz_rng) begin
                    tag_d        = TagReply;
                    rn16_d       = i_random_rng;
                    reply_rn16_d = 1'b1;
                end else begin
                    tag_d = TagArbitrate;
                end
            end
            default: begin
                if (i_cmd_valid_dec) begin
                    case (i_cmd_type_dec)
                        CmdQuery: begin
                            q_d   = i_q_field_dec;
                            seq_d = SeqSlot;
                            dec_d = 1'b0;
                        end
                        CmdQueryRep: begin
                            case (tag_q)
                                TagArbitrate: begin
                                    seq_d = SeqSlot;
                                    dec_d = 1'b1;
                                end
                                TagReply: tag_d = TagArbitrate;
                                TagAcked: tag_d = TagReady;
                                default:  ;
                            endcase
                        end
                        CmdQueryAdj: begin
                            if (updn_ok) begin
                                if (tag_q == TagArbitrate || tag_q == TagReply) begin
                                    if (i_updn_dec == UpdnInc && q_q != 4'd15) begin
                                        q_d = q_q + 4'd1;
                                    end else if (i_updn_dec == UpdnDec && q_q != 4'd0) begin
                                        q_d = q_q - 4'd1;
                                    end
                                    seq_d = SeqSlot;
                                    dec_d = 1'b0;
                                end else if (tag_q == TagAcked) begin
                                    tag_d = TagReady;
                                end
                            end
                        end
                        CmdAck: begin
                            if (tag_q == TagReply || tag_q == TagAcked) begin
                                if (i_rn16_dec == rn16_q) begin
                                    tag_d       = TagAcked;
                                    reply_epc_d = 1'b1;
                                end else begin
                                    tag_d = TagArbitrate;
                                end
                            end
                        end
                        CmdNak: begin
                            if (tag_q != TagReady) begin
                                tag_d = TagArbitrate;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= TagReady;
            seq_q        <= SeqIdle;
            q_q          <= 4'd0;
            rn16_q       <= 16'd0;
            dec_q        <= 1'b0;
            reply_rn16_q <= 1'b0;
            reply_epc_q  <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            seq_q        <= seq_d;
            q_q          <= q_d;
            rn16_q       <= rn16_d;
            dec_q        <= dec_d;
            reply_rn16_q <= reply_rn16_d;
            reply_epc_q  <= reply_epc_d;
        end
    end

    // Outputs: slot strobes decode directly from the SLOT phase, so they cannot overlap.
    always_comb begin
        o_q_cu          = q_q;
        o_newSlot_cu    = (seq_q == SeqSlot) && !dec_q;
        o_decSlot_cu    = (seq_q == SeqSlot) && dec_q;
        o_reply_rn16_cu = reply_rn16_q;
        o_reply_epc_cu  = reply_epc_q;
        o_rn16_cu       = rn16_q;
        o_state_cu      = tag_q;
        o_busy_cu       = (seq_q != SeqIdle);
    end

endmodule

// File: tb/tb_inventory_ctrl.sv
// Self-checking bench for inventory_ctrl: directed plan steps followed by random commands,
// all checked against a rule-level tag model.
module tb_inventory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cmd_valid_dec;
    logic [2:0]  i_cmd_type_dec;
    logic [3:0]  i_q_field_dec;
    logic [2:0]  i_updn_dec;
    logic [15:0] i_rn16_dec;
    logic [15:0] i_random_rng;
    logic        i_slotz_rng;
    logic [3:0]  o_q_cu;
    logic        o_newSlot_cu;
    logic        o_decSlot_cu;
    logic        o_reply_rn16_cu;
    logic        o_reply_epc_cu;
    logic [15:0] o_rn16_cu;
    logic [1:0]  o_state_cu;
    logic        o_busy_cu;

    always #5 clk = ~clk;

    inventory_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cmd_valid_dec (i_cmd_valid_dec),
        .i_cmd_type_dec  (i_cmd_type_dec),
        .i_q_field_dec   (i_q_field_dec),
        .i_updn_dec      (i_updn_dec),
        .i_rn16_dec      (i_rn16_dec),
        .i_random_rng    (i_random_rng),
        .i_slotz_rng     (i_slotz_rng),
        .o_q_cu          (o_q_cu),
        .o_newSlot_cu    (o_newSlot_cu),
        .o_decSlot_cu    (o_decSlot_cu),
        .o_reply_rn16_cu (o_reply_rn16_cu),
        .o_reply_epc_cu  (o_reply_epc_cu),
        .o_rn16_cu       (o_rn16_cu),
        .o_state_cu      (o_state_cu),
        .o_busy_cu       (o_busy_cu)
    );

    int checks = 0;
    int failures = 0;

    // Tag model: 0 READY, 1 ARBITRATE, 2 REPLY, 3 ACKNOWLEDGED
    int m_st = 0;
    int m_q = 0;
    int m_rn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one command to the model. kind: 0 none, 1 new-slot, 2 dec-slot sequence.
    task automatic model_cmd(input int t, input int qf, input int ud, input int rn,
                             input int sz, input int rnd, output int kind, output int epc);
        bit ud_ok;
        kind = 0;
        epc = 0;
        ud_ok = (ud == 6) || (ud == 3) || (ud == 0);
        case (t)
            0: begin
                m_q = qf;
                kind = 1;
            end
            1: begin
                if (m_st == 1) kind = 2;
                else if (m_st == 2) m_st = 1;
                else if (m_st == 3) m_st = 0;
            end
            2: begin
                if (ud_ok && (m_st == 1 || m_st == 2)) begin
                    if (ud == 6) m_q = (m_q == 15) ? 15 : m_q + 1;
                    if (ud == 3) m_q = (m_q == 0) ? 0 : m_q - 1;
                    kind = 1;
                end else if (ud_ok && m_st == 3) begin
                    m_st = 0;
                end
            end
            3: begin
                if (m_st >= 2) begin
                    if (rn == m_rn) begin
                        m_st = 3;
                        epc = 1;
                    end else begin
                        m_st = 1;
                    end
                end
            end
            4: if (m_st != 0) m_st = 1;
            default: ;
        endcase
        if (kind != 0) begin
            if (sz != 0) begin
                m_st = 2;
                m_rn = rnd;
            end else begin
                m_st = 1;
            end
        end
    endtask

    // mode 0: plain command; 1: extra Query injected while busy; 2: reset pulled during C+1
    task automatic do_cmd(input int t, input int qf, input int ud, input int rn,
                          input int sz, input int rnd, input int mode);
        int prev_st, prev_q, prev_rn, kind, epc, exp_q;
        prev_st = m_st;
        prev_q = m_q;
        prev_rn = m_rn;
        @(negedge clk);
        i_cmd_valid_dec = 1'b1;
        i_cmd_type_dec  = t[2:0];
        i_q_field_dec   = qf[3:0];
        i_updn_dec      = ud[2:0];
        i_rn16_dec      = rn[15:0];
        i_slotz_rng     = sz[0];
        i_random_rng    = rnd[15:0];
        @(negedge clk);
        i_cmd_valid_dec = 1'b0;
        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            m_st = 0;
            m_q = 0;
            m_rn = 0;
            chk("rst_mid_state", o_state_cu, 0);
            chk("rst_mid_q", o_q_cu, 0);
            chk("rst_mid_rn16", o_rn16_cu, 0);
            chk("rst_mid_busy", o_busy_cu, 0);
            chk("rst_mid_strobes", {o_newSlot_cu, o_decSlot_cu, o_reply_rn16_cu,
                                    o_reply_epc_cu}, 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("post_rst_quiet", {o_newSlot_cu, o_decSlot_cu, o_reply_rn16_cu,
                                       o_reply_epc_cu, o_busy_cu}, 0);
                chk("post_rst_state", o_state_cu, 0);
            end
        end else begin
            model_cmd(t, qf, ud, rn, sz, rnd, kind, epc);
            exp_q = m_q;
            // C+1
            chk("c1_q", o_q_cu, exp_q);
            chk("c1_newslot", o_newSlot_cu, kind == 1);
            chk("c1_decslot", o_decSlot_cu, kind == 2);
            chk("c1_busy", o_busy_cu, kind != 0);
            chk("c1_epc", o_reply_epc_cu, epc);
            chk("c1_reply_rn16", o_reply_rn16_cu, 0);
            chk("c1_state", o_state_cu, (kind != 0) ? prev_st : m_st);
            if (mode == 1) begin
                i_cmd_valid_dec = 1'b1;
                i_cmd_type_dec  = 3'd0;
                i_q_field_dec   = ~qf[3:0];
            end
            if (kind != 0) begin
                @(negedge clk);
                i_cmd_valid_dec = 1'b0;
                // C+2
                chk("c2_busy", o_busy_cu, 1);
                chk("c2_slot_strobes", {o_newSlot_cu, o_decSlot_cu}, 0);
                chk("c2_reply_rn16", o_reply_rn16_cu, 0);
                chk("c2_state", o_state_cu, prev_st);
                chk("c2_rn16", o_rn16_cu, prev_rn);
                chk("c2_q", o_q_cu, exp_q);
                @(negedge clk);
                // C+3
                chk("c3_state", o_state_cu, m_st);
                chk("c3_rn16", o_rn16_cu, m_rn);
                chk("c3_reply_rn16", o_reply_rn16_cu, sz != 0);
                chk("c3_busy", o_busy_cu, 0);
                chk("c3_q", o_q_cu, exp_q);
                @(negedge clk);
                chk("c4_reply_rn16", o_reply_rn16_cu, 0);
            end else begin
                @(negedge clk);
                i_cmd_valid_dec = 1'b0;
                chk("c2_epc_drop", o_reply_epc_cu, 0);
                chk("c2_idle_state", o_state_cu, m_st);
            end
            if (prev_q < 0) chk("unused", 0, 1);
        end
    endtask

    initial begin
        int t, qf, ud, rn, sz, rnd;
        rst_n           = 1'b0;
        i_cmd_valid_dec = 1'b0;
        i_cmd_type_dec  = 3'd0;
        i_q_field_dec   = 4'd0;
        i_updn_dec      = 3'd0;
        i_rn16_dec      = 16'd0;
        i_random_rng    = 16'd0;
        i_slotz_rng     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", o_state_cu, 0);
        chk("reset_q", o_q_cu, 0);
        chk("reset_rn16", o_rn16_cu, 0);
        chk("reset_busy", o_busy_cu, 0);
        chk("reset_strobes", {o_newSlot_cu, o_decSlot_cu, o_reply_rn16_cu, o_reply_epc_cu}, 0);
        rst_n = 1'b1;

        // Query Q=0 with slot hit
        do_cmd(0, 0, 0, 0, 1, 16'hBEAF, 0);
        chk("beaf_latched", o_rn16_cu, 16'hBEAF);
        // Query Q=4 miss, then three QueryReps hitting on the third
        do_cmd(0, 4, 0, 0, 0, 16'h5555, 0);
        do_cmd(1, 0, 0, 0, 0, 16'h1111, 0);
        do_cmd(1, 0, 0, 0, 0, 16'h2222, 0);
        do_cmd(1, 0, 0, 0, 1, 16'h1234, 0);
        // ACK handling
        do_cmd(3, 0, 0, 16'h1234, 0, 0, 0);
        do_cmd(3, 0, 0, 16'h1234, 0, 0, 0);
        do_cmd(3, 0, 0, 16'h1235, 0, 0, 0);
        // QueryAdjust boundaries
        do_cmd(0, 15, 0, 0, 0, 16'h0F0F, 0);
        do_cmd(2, 0, 3'b110, 0, 0, 16'h0F0F, 0);
        do_cmd(0, 0, 0, 0, 0, 16'h0A0A, 0);
        do_cmd(2, 0, 3'b011, 0, 0, 16'h0A0A, 0);
        do_cmd(2, 0, 3'b101, 0, 1, 16'h0B0B, 0);
        // Command while busy is dropped
        do_cmd(0, 5, 0, 0, 0, 16'h7777, 1);
        // Reach READY, then NAK and type 6 do nothing
        do_cmd(0, 2, 0, 0, 1, 16'hCAFE, 0);
        do_cmd(3, 0, 0, 16'hCAFE, 0, 0, 0);
        do_cmd(1, 0, 0, 0, 0, 0, 0);
        do_cmd(4, 0, 0, 0, 0, 0, 0);
        do_cmd(6, 9, 0, 0, 1, 16'h9999, 0);
        // Reset mid-sequence
        do_cmd(0, 3, 0, 0, 1, 16'hDEAD, 2);

        for (int i = 0; i < 300; i++) begin
            t   = $urandom_range(7);
            qf  = $urandom_range(15);
            case ($urandom_range(4))
                0: ud = 6;
                1: ud = 3;
                2: ud = 0;
                default: ud = $urandom_range(7);
            endcase
            rn  = ($urandom_range(1) == 1) ? m_rn : $urandom_range(16'hFFFF);
            sz  = $urandom_range(1);
            rnd = $urandom_range(16'hFFFF);
            do_cmd(t, qf, ud, rn, sz, rnd, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inventory_ctrl.md
# inventory_ctrl

Gen2 tag inventory control unit. Consumes decoded inventory commands, runs the Ready/Arbitrate/Reply/Acknowledged tag state machine, and drives the slot counter inside the random-number/slot block (Q value, new-slot and decrement-slot strobes). It samples that block's slot-zero flag and random word to decide when to backscatter an RN16. It then validates ACKs against the latched RN16 before requesting the EPC reply.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_cmd_valid_dec  in  1  one-cycle strobe: decoded command valid
- i_cmd_type_dec  in  3  0 Query, 1 QueryRep, 2 QueryAdjust, 3 ACK, 4 NAK; 5-7 ignored
- i_q_field_dec  in  4  Q field of Query
- i_updn_dec  in  3  QueryAdjust UpDn: 3'b110 Q+1, 3'b011 Q-1, 3'b000 keep; other codes are ignored
- i_rn16_dec  in  16  RN16 field of ACK
- i_random_rng  in  16  current random word from RNG
- i_slotz_rng  in  1  masked slot counter == 0
- o_q_cu  out  4  current Q, feeds RNG slot mask
- o_newSlot_cu  out  1  one-cycle strobe: load slot from random word
- o_decSlot_cu  out  1  one-cycle strobe: decrement slot
- o_reply_rn16_cu  out  1  one-cycle strobe: transmit o_rn16_cu
- o_reply_epc_cu  out  1  one-cycle strobe: transmit EPC
- o_rn16_cu  out  16  RN16 latched on slot hit
- o_state_cu  out  2  0 READY, 1 ARBITRATE, 2 REPLY, 3 ACKNOWLEDGED
- o_busy_cu  out  1  slot update/evaluation in progress

## Operation
- Reset: state READY, Q 0, o_rn16_cu 0, all strobes 0, o_busy_cu 0.
- Sequencer phases are IDLE, SLOT, and EVAL. A slot-affecting command moves the sequencer IDLE->SLOT->EVAL->IDLE. In SLOT, exactly one of o_newSlot_cu or o_decSlot_cu is high. In EVAL, i_slotz_rng is sampled.
- EVAL outcome:
  - slotz=1: state REPLY, o_rn16_cu <= i_random_rng, o_reply_rn16_cu pulses.
  - slotz=0: state ARBITRATE.
- Query, any state: Q <= i_q_field_dec; newSlot sequence.
- QueryRep:
  - ARBITRATE: decSlot sequence.
  - REPLY: ->ARBITRATE, no strobe.
  - ACKNOWLEDGED: ->READY.
  - READY: ignored.
- QueryAdjust:
  - ARBITRATE/REPLY: update Q; Q+1 saturates at 15, Q-1 saturates at 0; then newSlot sequence (also for 000).
  - ACKNOWLEDGED: ->READY with Q unchanged.
  - READY or invalid UpDn: ignored.
- ACK:
  - REPLY or ACKNOWLEDGED with i_rn16_dec == o_rn16_cu: ->ACKNOWLEDGED, o_reply_epc_cu pulses.
  - REPLY or ACKNOWLEDGED with mismatch: ->ARBITRATE.
  - Other states: ignored.
- NAK: ARBITRATE/REPLY/ACKNOWLEDGED ->ARBITRATE; READY ignored.
- Commands with i_cmd_valid_dec while o_busy_cu=1 are dropped with no effect. Type codes 5-7 are always ignored.
- o_newSlot_cu and o_decSlot_cu are never high together. No strobe is ever high for more than one cycle.

## Timing
- Command sampled at posedge ending cycle C. o_busy_cu=1 during C+1 and C+2.
- C+1: newSlot/decSlot strobe high. The RNG loads or decrements slot at the end of C+1.
- C+2: i_slotz_rng and i_random_rng are sampled at the posedge ending C+2.
- C+3: o_state_cu updated; o_reply_rn16_cu high for one cycle; o_rn16_cu valid and held until the next hit or reset.
- Non-sequenced commands (ACK, NAK, QueryRep in REPLY/ACK'd, QueryAdjust in ACK'd): state and o_reply_epc_cu update at C+1, with latency 1.
- o_q_cu changes at C+1 for Query/QueryAdjust. It is therefore stable before the RNG samples the slot mask.
- Reset asserted mid-sequence aborts the sequence immediately. All outputs go to their reset values asynchronously. No strobe is emitted after reset release until a new command arrives.

## Test plan
- Bench drives i_random_rng/i_slotz_rng directly.
- Query Q=0, slotz=1, random=16'hBEAF -> newSlot at C+1, state REPLY and o_rn16_cu=16'hBEAF at C+3, one reply_rn16 pulse.
- Query Q=4, slotz=0 -> ARBITRATE. Then three QueryReps with slotz 0,0,1 -> three decSlot pulses; REPLY after the third with RN16 latched.
- From REPLY with rn16=16'h1234: ACK 16'h1234 -> ACKNOWLEDGED plus epc pulse at C+1. Repeat ACK -> second epc pulse, state unchanged. ACK 16'h1235 -> ARBITRATE, no pulse.
- QueryAdjust boundaries: Q=15 with 110 -> Q stays 15 and newSlot pulses. Q=0 with 011 -> Q stays 0. UpDn 3'b101 -> no change, no strobe.
- Command issued at C+1 while busy -> dropped, state/Q unchanged. NAK in READY -> no effect. Type 6 -> no effect.
- rst_n low during C+1 of a Query -> all outputs reset. No EVAL or reply pulse follows; state stays READY.
